intr_ctrl85: RTL and testbench

//  Interrupt controller for the 8085 core: synchronises TRAP/RST7.5/RST6.5/RST5.5/INTR,

---
 rtl/intr_ctrl85.sv | 150 +++++++++++++++
 tb/tb_intr_ctrl85.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl85.sv
// 8085 interrupt controller: pin synchronisers, SIM/RIM state, IE/EI-shadow handling
// and fixed-priority selection of one request plus vector for the control sequencer.
module intr_ctrl85 #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDRSIZE    = 16
) (
  input  logic                CLK,
  input  logic                RST_,
  input  logic                TRAP,
  input  logic                RST75,
  input  logic                RST65,
  input  logic                RST55,
  input  logic                INTR,
  input  logic                SID,
  input  logic                INST_END,
  input  logic                EI_SET,
  input  logic                DI_SET,
  input  logic                SIM_WR,
  input  logic [7:0]          SIM_DATA,
  input  logic                IACK,
  output logic                IRQ,
  output logic [2:0]          ISRC,
  output logic [ADDRSIZE-1:0] IVEC,
  output logic                IE,
  output logic [7:0]          RIM_DATA,
  output logic                SOD
);

  localparam logic [2:0] SRC_NONE = 3'b000;
  localparam logic [2:0] SRC_INTR = 3'b001;
  localparam logic [2:0] SRC_R55  = 3'b010;
  localparam logic [2:0] SRC_R65  = 3'b011;
  localparam logic [2:0] SRC_R75  = 3'b100;
  localparam logic [2:0] SRC_TRAP = 3'b101;

  // Highest set bit wins: {trap, 7.5, 6.5, 5.5, intr}
  function automatic logic [2:0] pick_src(input logic [4:0] req);
    logic [2:0] src;
    src = SRC_NONE;
    if (req[4])      src = SRC_TRAP;
    else if (req[3]) src = SRC_R75;
    else if (req[2]) src = SRC_R65;
    else if (req[1]) src = SRC_R55;
    else if (req[0]) src = SRC_INTR;
    return src;
  endfunction

  function automatic logic [ADDRSIZE-1:0] vec_of(input logic [2:0] src);
    logic [7:0] v;
    case (src)
      SRC_TRAP: v = 8'h24;
      SRC_R75:  v = 8'h3C;
      SRC_R65:  v = 8'h34;
      SRC_R55:  v = 8'h2C;
      default:  v = 8'h00;
    endcase
    return ADDRSIZE'(v);
  endfunction

  logic [5:0] pins;
  logic [5:0] sync_p [SYNC_STAGES];
  logic [5:0] pins_s;
  logic [1:0] edge_q;

  assign pins = {SID, INTR, RST55, RST65, RST75, TRAP};

  // Synchroniser chain: stage 0 samples the raw pins, the last stage is the _s view
  always_ff @(posedge CLK) begin
    if (!RST_) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_p[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      edge_q <= pins_s[1:0];
    end
  end

  assign pins_s = sync_p[SYNC_STAGES-1];

  logic trap_s, r75_s, r65_s, r55_s, intr_s, sid_s;
  logic trap_rise, r75_rise;

  assign trap_s    = pins_s[0];
  assign r75_s     = pins_s[1];
  assign r65_s     = pins_s[2];
  assign r55_s     = pins_s[3];
  assign intr_s    = pins_s[4];
  assign sid_s     = pins_s[5];
  assign trap_rise = trap_s & ~edge_q[0];
  assign r75_rise  = r75_s & ~edge_q[1];

  logic       ie_q, blk_q, r75_q, trp_q, sod_q;
  logic [2:0] mask_q;
  logic       gate;
  logic [4:0] req;
  logic       take;

  assign gate = ie_q & ~blk_q;
  assign req  = {trp_q & trap_s,
                 gate & r75_q & ~mask_q[2],
                 gate & r65_s & ~mask_q[1],
                 gate & r55_s & ~mask_q[0],
                 gate & intr_s};
  assign IRQ  = |req;
  assign ISRC = pick_src(req);
  assign IVEC = vec_of(ISRC);
  assign take = IACK & IRQ;

  // Control state: a fresh edge always outranks a same-cycle clear of its latch
  always_ff @(posedge CLK) begin
    if (!RST_) begin
      ie_q   <= 1'b0;
      blk_q  <= 1'b0;
      mask_q <= 3'b111;
      r75_q  <= 1'b0;
      trp_q  <= 1'b0;
      sod_q  <= 1'b0;
    end else begin
      if (trap_rise)                                trp_q <= 1'b1;
      else if (!trap_s || (take && ISRC == SRC_TRAP)) trp_q <= 1'b0;

      if (r75_rise)                                 r75_q <= 1'b1;
      else if ((take && ISRC == SRC_R75) || (SIM_WR && SIM_DATA[4]))
                                                    r75_q <= 1'b0;

      // blk holds off maskable requests until the instruction after EI completes
      if (take || DI_SET) begin
        ie_q  <= 1'b0;
        blk_q <= 1'b0;
      end else if (EI_SET) begin
        ie_q  <= 1'b1;
        blk_q <= 1'b1;
      end else if (INST_END) begin
        blk_q <= 1'b0;
      end

      if (SIM_WR && SIM_DATA[3]) mask_q <= SIM_DATA[2:0];
      if (SIM_WR && SIM_DATA[6]) sod_q  <= SIM_DATA[7];
    end
  end

  logic unused_sim;
  assign unused_sim = SIM_DATA[5];

  assign IE       = ie_q;
  assign SOD      = sod_q;
  assign RIM_DATA = {sid_s, r75_q, r65_s, r55_s, ie_q, mask_q};

endmodule

// File: tb/tb_intr_ctrl85.sv
// Self-checking bench for intr_ctrl85: directed scenarios plus randomized traffic
// compared every cycle against a rule-level reference model.
module tb_intr_ctrl85;
  localparam int SS = 2;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RST_, TRAP, RST75, RST65, RST55, INTR, SID;
  logic          INST_END, EI_SET, DI_SET, SIM_WR, IACK;
  logic [7:0]    SIM_DATA;
  logic          IRQ, IE, SOD;
  logic [2:0]    ISRC;
  logic [AW-1:0] IVEC;
  logic [7:0]    RIM_DATA;

  int n_vec = 0;
  int n_err = 0;

  intr_ctrl85 #(.SYNC_STAGES(SS), .ADDRSIZE(AW)) dut (
    .CLK(CLK), .RST_(RST_), .TRAP(TRAP), .RST75(RST75), .RST65(RST65),
    .RST55(RST55), .INTR(INTR), .SID(SID), .INST_END(INST_END),
    .EI_SET(EI_SET), .DI_SET(DI_SET), .SIM_WR(SIM_WR), .SIM_DATA(SIM_DATA),
    .IACK(IACK), .IRQ(IRQ), .ISRC(ISRC), .IVEC(IVEC), .IE(IE),
    .RIM_DATA(RIM_DATA), .SOD(SOD)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin history queue gives the synchronised view directly
  logic [5:0] m_hist[$];
  logic [5:0] m_prev;
  bit         m_ie, m_blk, m_r75, m_trp, m_sod;
  bit [2:0]   m_mask;

  function automatic void m_eval(output bit irq, output int src);
    logic [5:0] s;
    bit req[6];
    bit g;
    s = m_hist[0];
    g = m_ie && !m_blk;
    req[5] = m_trp && s[0];
    req[4] = g && m_r75 && !m_mask[2];
    req[3] = g && s[2] && !m_mask[1];
    req[2] = g && s[3] && !m_mask[0];
    req[1] = g && s[4];
    req[0] = 1'b0;
    src = 0;
    for (int k = 5; k >= 1; k--) if (req[k] && src == 0) src = k;
    irq = (src != 0);
  endfunction

  function automatic int vec_of(input int src);
    case (src)
      5: return 'h24;
      4: return 'h3C;
      3: return 'h34;
      2: return 'h2C;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_word();
    bit irq; int src; logic [5:0] s; logic [7:0] rim;
    m_eval(irq, src);
    s = m_hist[0];
    rim = {s[5], m_r75, s[2], s[3], m_ie, m_mask};
    return {2'b00, irq, src[2:0], 16'(vec_of(src)), m_ie, rim, m_sod};
  endfunction

  function automatic logic [31:0] dut_word();
    return {2'b00, IRQ, ISRC, IVEC, IE, RIM_DATA, SOD};
  endfunction

  task automatic model_update();
    bit irq, take; int src; logic [5:0] s;
    if (!RST_) begin
      m_hist = {};
      repeat (SS) m_hist.push_back(6'b0);
      m_prev = '0;
      m_ie = 0; m_blk = 0; m_r75 = 0; m_trp = 0; m_sod = 0; m_mask = 3'b111;
    end else begin
      m_eval(irq, src);
      take = IACK && irq;
      s = m_hist[0];
      if (s[0] && !m_prev[0]) m_trp = 1;
      else if (!s[0] || (take && src == 5)) m_trp = 0;
      if (s[1] && !m_prev[1]) m_r75 = 1;
      else if ((take && src == 4) || (SIM_WR && SIM_DATA[4])) m_r75 = 0;
      if (take || DI_SET) begin m_ie = 0; m_blk = 0; end
      else if (EI_SET) begin m_ie = 1; m_blk = 1; end
      else if (INST_END) m_blk = 0;
      if (SIM_WR && SIM_DATA[3]) m_mask = SIM_DATA[2:0];
      if (SIM_WR && SIM_DATA[6]) m_sod = SIM_DATA[7];
      m_prev = s;
      void'(m_hist.pop_front());
      m_hist.push_back({SID, INTR, RST55, RST65, RST75, TRAP});
    end
  endtask

  task automatic step();
    model_update();
    @(posedge CLK);
    #1;
    chk("cycle", dut_word(), model_word());
    INST_END = 0; EI_SET = 0; DI_SET = 0; SIM_WR = 0; IACK = 0;
  endtask

  task automatic do_reset();
    RST_ = 0; step(); RST_ = 1;
  endtask

  task automatic sim(input logic [7:0] d);
    SIM_WR = 1; SIM_DATA = d; INST_END = 1; step();
  endtask

  task automatic ei();
    EI_SET = 1; INST_END = 1; step();
  endtask

  task automatic iend();
    INST_END = 1; step();
  endtask

  initial begin
    RST_ = 0; TRAP = 0; RST75 = 0; RST65 = 0; RST55 = 0; INTR = 0; SID = 0;
    INST_END = 0; EI_SET = 0; DI_SET = 0; SIM_WR = 0; IACK = 0; SIM_DATA = '0;
    @(negedge CLK);
    do_reset();
    chk("reset_word", dut_word(), 32'h0000_000E);

    // Masked requests stay invisible to IRQ but show in RIM
    RST55 = 1; RST65 = 1; RST75 = 1; step();
    RST75 = 0; ei();
    repeat (4) step();
    chk("t1_irq", {31'b0, IRQ}, 32'd0);
    chk("t1_rim", {24'b0, RIM_DATA}, 32'h7F);

    do_reset();
    RST55 = 0; RST65 = 0;
    sim(8'h08); ei(); iend();
    RST65 = 1; step();
    chk("t2_early", {31'b0, IRQ}, 32'd0);
    step();
    chk("t2_src", {29'b0, ISRC}, 32'd3);
    chk("t2_vec", {16'b0, IVEC}, 32'h34);
    IACK = 1; step();
    chk("t2_ack", {30'b0, IE, IRQ}, 32'd0);

    RST65 = 0; RST55 = 1; ei();
    step(); step();
    chk("t3_blk", {31'b0, IRQ}, 32'd0);
    iend();
    chk("t3_vec", {15'b0, IRQ, IVEC}, 32'h1_002C);
    IACK = 1; step();

    RST55 = 0; TRAP = 1; step(); step();
    chk("t4_early", {31'b0, IRQ}, 32'd0);
    step();
    chk("t4_trap", {12'b0, IRQ, ISRC, IVEC}, {12'b0, 1'b1, 3'd5, 16'h24});
    TRAP = 0; step(); step();
    chk("t4_drop", {31'b0, IRQ}, 32'd0);

    do_reset();
    RST75 = 1; step(); RST75 = 0;
    repeat (3) step();
    chk("t5_latch", {31'b0, RIM_DATA[6]}, 32'd1);
    sim(8'h10);
    chk("t5_clear", {31'b0, RIM_DATA[6]}, 32'd0);
    RST75 = 1; step(); RST75 = 0; step();
    sim(8'h10);
    chk("t5_race", {31'b0, RIM_DATA[6]}, 32'd1);

    do_reset();
    sim(8'h08); ei(); iend();
    RST75 = 1; RST55 = 1; INTR = 1; step(); RST75 = 0;
    repeat (3) step();
    chk("t6_r75", {29'b0, ISRC}, 32'd4);
    IACK = 1; step();
    chk("t6_ack", {31'b0, IRQ}, 32'd0);
    ei(); iend();
    chk("t6_r55", {29'b0, ISRC}, 32'd2);
    IACK = 1; RST55 = 0; step();
    ei(); iend();
    chk("t6_intr", {29'b0, ISRC}, 32'd1);
    sim(8'hC0);
    chk("t6_sod", {31'b0, SOD}, 32'd1);
    RST_ = 0; step(); RST_ = 1;
    chk("t6_reset", dut_word(), 32'h0000_000E);
    INTR = 0;

    // Randomized traffic including collisions and occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit irq; int src; int r;
      RST_ = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0) TRAP  = ~TRAP;
      if ($urandom_range(0, 9)  == 0) RST75 = ~RST75;
      if ($urandom_range(0, 9)  == 0) RST65 = ~RST65;
      if ($urandom_range(0, 9)  == 0) RST55 = ~RST55;
      if ($urandom_range(0, 9)  == 0) INTR  = ~INTR;
      if ($urandom_range(0, 7)  == 0) SID   = ~SID;
      r = $urandom_range(0, 99);
      if (r < 10)      begin EI_SET = 1; INST_END = 1; end
      else if (r < 14) begin DI_SET = 1; INST_END = 1; end
      else if (r < 24) begin SIM_WR = 1; SIM_DATA = 8'($urandom); INST_END = 1; end
      else if (r < 55) INST_END = 1;
      if ($urandom_range(0, 49) == 0) DI_SET = 1;
      m_eval(irq, src);
      if (irq && $urandom_range(0, 2) == 0) IACK = 1;
      else if ($urandom_range(0, 19) == 0) IACK = 1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
